// File: rtl/data_memory.sv
// 256 x 8 byte-addressable data memory: combinational read, synchronous write.
// mem_core is left as a plain array so benches can preload and inspect it hierarchically.
module data_memory #(
    parameter int W             = 8,
    parameter int A             = 8,
    parameter bit INIT_ON_RESET = 1'b0
) (
    input  logic         clk,
    input  logic         reset = 1'b0,
    input  logic         ReadMem,
    input  logic         WriteMem,
    input  logic [A-1:0] DataAddress,
    input  logic [W-1:0] DataIn,
    output logic [W-1:0] DataOut
);

    logic [W-1:0] mem_core [0:2**A-1];

    // Read is a pure mux: it follows address and array changes with no clock, no bypass.
    always_comb begin
        DataOut = '0;
        if (ReadMem) begin
            DataOut = mem_core[DataAddress];
        end
    end

    // NOTE: array state uses <= so a same-edge read sees the old byte, never the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: clearing the array is optional; by default reset keeps preloaded contents.
            if (INIT_ON_RESET) begin
                for (int i = 0; i < 2**A; i++) begin
                    mem_core[i] <= '0;
                end
            end
        end else if (WriteMem) begin
            mem_core[DataAddress] <= DataIn;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: one instance with contents preserved on reset,
// one with INIT_ON_RESET=1.
module tb_data_memory;

    logic       clk = 1'b0;

    logic       reset0 = 1'b0;
    logic       rd0 = 1'b0;
    logic       wr0 = 1'b0;
    logic [7:0] addr0 = 8'h00;
    logic [7:0] din0 = 8'h00;
    logic [7:0] dout0;

    logic       reset1 = 1'b0;
    logic       rd1 = 1'b0;
    logic       wr1 = 1'b0;
    logic [7:0] addr1 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [7:0] dout1;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory #(.W(8), .A(8), .INIT_ON_RESET(1'b0)) dut0 (
        .clk         (clk),
        .reset       (reset0),
        .ReadMem     (rd0),
        .WriteMem    (wr0),
        .DataAddress (addr0),
        .DataIn      (din0),
        .DataOut     (dout0)
    );

    data_memory #(.W(8), .A(8), .INIT_ON_RESET(1'b1)) dut1 (
        .clk         (clk),
        .reset       (reset1),
        .ReadMem     (rd1),
        .WriteMem    (wr1),
        .DataAddress (addr1),
        .DataIn      (din1),
        .DataOut     (dout1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        // Idle: read disabled gives zero, even with an unknown array.
        @(negedge clk);
        #1 check("idle_read_off", dout0, 8'h00);

        // Preloaded float operand read back combinationally.
        dut0.mem_core[4] = 8'h00;
        dut0.mem_core[5] = 8'h3C;
        rd0 = 1'b1; addr0 = 8'd5;
        #1 check("preload_addr5", dout0, 8'h3C);
        addr0 = 8'd4;
        #1 check("preload_addr4", dout0, 8'h00);

        // Read-during-write: old value before the edge, new value after, no bypass.
        @(negedge clk);
        dut0.mem_core[6] = 8'h11;
        wr0 = 1'b1; addr0 = 8'd6; din0 = 8'hFF;
        #1 check("rdw_before_edge", dout0, 8'h11);
        @(posedge clk);
        #1 check("rdw_after_edge", dout0, 8'hFF);
        check("rdw_array", dut0.mem_core[6], 8'hFF);
        @(negedge clk);
        wr0 = 1'b0;

        // Read enable gating.
        dut0.mem_core[7] = 8'h7F;
        rd0 = 1'b0; addr0 = 8'd7;
        #1 check("read_disabled", dout0, 8'h00);
        rd0 = 1'b1;
        #1 check("read_enabled", dout0, 8'h7F);

        // Reset suppresses a coincident write and keeps preloads when INIT_ON_RESET=0.
        @(negedge clk);
        dut0.mem_core[10] = 8'h33;
        dut0.mem_core[4]  = 8'h12;
        reset0 = 1'b1; wr0 = 1'b1; addr0 = 8'd10; din0 = 8'hA5;
        @(posedge clk);
        #1 check("reset_drops_write", dut0.mem_core[10], 8'h33);
        check("reset_keeps_preload", dut0.mem_core[4], 8'h12);
        check("reset_read_path", dout0, 8'h33);
        @(negedge clk);
        reset0 = 1'b0;
        @(posedge clk);
        #1 check("write_resumes", dout0, 8'hA5);
        @(negedge clk);
        wr0 = 1'b0;

        // INIT_ON_RESET=1 clears the array, including both ends.
        dut1.mem_core[0]   = 8'h55;
        dut1.mem_core[255] = 8'hAA;
        rd1 = 1'b1; addr1 = 8'd0;
        #1 check("init_pre_addr0", dout1, 8'h55);
        reset1 = 1'b1; wr1 = 1'b1; din1 = 8'hC3;
        @(posedge clk);
        #1 check("init_clear_addr0", dout1, 8'h00);
        addr1 = 8'd255;
        #1 check("init_clear_addr255", dout1, 8'h00);
        @(negedge clk);
        reset1 = 1'b0; addr1 = 8'd255; din1 = 8'hC3;
        @(posedge clk);
        #1 check("init_then_write", dout1, 8'hC3);
        @(negedge clk);
        wr1 = 1'b0;

        // Back-to-back sweep: every address written with its own value.
        rd0 = 1'b0; wr0 = 1'b1;
        for (int a = 0; a < 256; a++) begin
            addr0 = 8'(a); din0 = 8'(a);
            @(negedge clk);
        end
        wr0 = 1'b0; rd0 = 1'b1;
        for (int a = 0; a < 256; a++) begin
            addr0 = 8'(a);
            #1 check($sformatf("sweep_addr%0d", a), dout0, 8'(a));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable 256 x 8 single-port data memory for the CSE141L processor programs (e.g. flt2int, int2flt).
- Combinational read, synchronous write.
- The storage array is named mem_core and is hierarchically visible so testbenches can preload operands and inspect results directly. Example: float operand in mem_core[5:4], integer result in mem_core[7:6], high byte at the higher address.

Parameters:
- W, 8, data width in bits.
- A, 8, address width in bits; depth = 2**A.
- INIT_ON_RESET, 0, when 1 reset clears every mem_core entry; when 0 reset leaves contents untouched.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; port default value 0 so instances that omit it still elaborate.
- ReadMem  input  1  read enable.
- WriteMem  input  1  write enable, sampled at posedge clk.
- DataAddress  input  A  byte address for both read and write.
- DataIn  input  W  write data.
- DataOut  output  W  read data.

Behaviour:
- Storage: logic [W-1:0] mem_core [0:2**A-1]. Name and shape are fixed for hierarchical access, e.g. {mem_core[5],mem_core[4]}. No power-up initialization is required; simulation may show X until written or preloaded.
- Read is combinational:
  - DataOut = mem_core[DataAddress] whenever ReadMem=1.
  - DataOut = 0 when ReadMem=0.
  - Zero latency; follows address and array changes within the same delta cycle, including hierarchical writes by the bench.
- Write at posedge clk: if WriteMem=1 and reset=0, mem_core[DataAddress] <= DataIn. Only one byte is written per cycle.
- Simultaneous read and write to the same address:
  - DataOut shows the old value until the clock edge.
  - DataOut shows DataIn after the edge, with no bypass.
- ReadMem and WriteMem are independent; both high is legal.
- Reset at posedge clk with reset=1:
  - Writes are suppressed that cycle.
  - If INIT_ON_RESET=1, all entries become 0.
  - If INIT_ON_RESET=0, contents are preserved; this is the default, so bench preloads survive reset.
  - Reset has no effect on the combinational read path.
- Reset asserted mid-sequence: a write coincident with reset is dropped; normal writes resume on the first edge with reset=0.
- Address range: all 2**A addresses are valid. There is no wrap logic beyond natural truncation of the A-bit address.
- X/Z on DataAddress while reading: DataOut is X; no error is flagged.
- Not intended to infer a specific RAM macro. The model must be synthesizable as registers plus a mux.

Test Plan:
- Preload mem_core[4]=8'h00, mem_core[5]=8'h3C hierarchically; ReadMem=1, DataAddress=5 -> DataOut=8'h3C in the same cycle. DataAddress=4 -> 8'h00.
- WriteMem=1, DataAddress=6, DataIn=8'hFF; posedge -> mem_core[6]=8'hFF. Before the edge, DataOut at addr 6 shows the old value; after the edge it shows 8'hFF.
- ReadMem=0 with mem_core[7]=8'h7F and DataAddress=7 -> DataOut=8'h00. Raise ReadMem -> DataOut=8'h7F.
- reset=1, WriteMem=1, DataAddress=10, DataIn=8'hA5; posedge -> mem_core[10] unchanged. With INIT_ON_RESET=0, a preloaded mem_core[4]=8'h12 remains 8'h12.
- INIT_ON_RESET=1 with mem_core[0]=8'h55 and mem_core[255]=8'hAA; one reset edge -> both read 8'h00.
- Back-to-back writes to addresses 0..255 with DataIn=addr, then read every address -> DataOut equals address; address 255 does not alias 0.
